tt_lut_engine: RTL and testbench

TT_LUT_ENGINE -- requirements
Module: tt_lut_engine

---
 rtl/tt_pkg.sv | 14 +
 rtl/tt_lut_sel.sv | 15 +
 rtl/tt_lut_engine.sv | 121 ++++++++++++
 tb/tb_tt_lut_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table LUT engine: FSM state encoding and table sizing.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned tt_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_lut_sel.sv
// Combinational single-bit select from a truth table; used for both evaluation and sweep reads.
module tt_lut_sel
    import tt_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    localparam int unsigned TT_W = tt_width(N_IN)
) (
    input  logic [TT_W-1:0] tt,
    input  logic [N_IN-1:0] sel,
    output logic            value
);

    assign value = tt[sel];

endmodule

// File: rtl/tt_lut_engine.sv
// Programmable N_IN-input truth-table engine with a ready/valid evaluation path and a
// self-sweep that reads the active table back and counts mismatches against an expected table.
module tt_lut_engine
    import tt_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    localparam int unsigned TT_W = tt_width(N_IN),
    parameter logic [TT_W-1:0] DEFAULT_TT = 16'h5215
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [TT_W-1:0] cfg_tt,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    input  logic            sweep_start,
    input  logic [TT_W-1:0] sweep_exp,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic [TT_W-1:0] sweep_tt,
    output logic [N_IN:0]   sweep_err_cnt
);

    localparam logic [N_IN-1:0] IDX_LAST = '1;
    localparam logic [N_IN-1:0] IDX_ONE  = 1;
    localparam logic [N_IN:0]   CNT_ONE  = 1;

    state_t          state_q;
    state_t          state_d;
    logic [TT_W-1:0] tt_q;
    logic [TT_W-1:0] exp_q;
    logic [N_IN-1:0] idx;
    logic            eval_bit;
    logic            sweep_bit;

    tt_lut_sel #(.N_IN(N_IN)) u_sel_eval (
        .tt    (tt_q),
        .sel   (in_vec),
        .value (eval_bit)
    );

    tt_lut_sel #(.N_IN(N_IN)) u_sel_sweep (
        .tt    (tt_q),
        .sel   (idx),
        .value (sweep_bit)
    );

    assign cfg_ready  = (state_q == IDLE);
    assign in_ready   = (state_q == IDLE) && (!out_valid || out_ready);
    assign sweep_busy = (state_q != IDLE);
    assign sweep_done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sweep_start) state_d = SWEEP;
            SWEEP:   if (idx == IDX_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A cfg load and an eval in the same cycle: eval_bit is sampled from the pre-load tt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q          <= DEFAULT_TT;
            exp_q         <= '0;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_bit       <= 1'b0;
            sweep_tt      <= '0;
            sweep_err_cnt <= '0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                tt_q <= cfg_tt;
            end

            if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                out_bit   <= eval_bit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        exp_q         <= sweep_exp;
                        sweep_tt      <= '0;
                        sweep_err_cnt <= '0;
                        idx           <= '0;
                    end
                end
                SWEEP: begin
                    sweep_tt[idx] <= sweep_bit;
                    if (sweep_bit != exp_q[idx]) begin
                        sweep_err_cnt <= sweep_err_cnt + CNT_ONE;
                    end
                    if (idx != IDX_LAST) begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_lut_engine.sv
// Directed self-checking bench for tt_lut_engine with the default 4-input configuration.
module tb_tt_lut_engine;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_tt;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_vec;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic        sweep_start;
    logic [15:0] sweep_exp;
    logic        sweep_busy;
    logic        sweep_done;
    logic [15:0] sweep_tt;
    logic [4:0]  sweep_err_cnt;

    int tests;
    int fails;

    tt_lut_engine #(.N_IN(4), .DEFAULT_TT(16'h5215)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_tt        (cfg_tt),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vec        (in_vec),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bit       (out_bit),
        .sweep_start   (sweep_start),
        .sweep_exp     (sweep_exp),
        .sweep_busy    (sweep_busy),
        .sweep_done    (sweep_done),
        .sweep_tt      (sweep_tt),
        .sweep_err_cnt (sweep_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; outputs are then read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep and reports the cycle numbers (1 = start edge) where done was seen
    // and how many cycles busy was high; bounded to 24 cycles.
    task automatic run_sweep(input logic [15:0] exp, output int done_at, output int busy_cycles);
        done_at     = -1;
        busy_cycles = 0;
        sweep_exp   = exp;
        sweep_start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            sweep_start = 1'b0;
            if (sweep_busy) busy_cycles++;
            if (sweep_done && done_at < 0) done_at = c;
            if (!sweep_busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if ({out_valid, out_bit, sweep_busy, sweep_done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_status: got %b required 0000", {out_valid, out_bit, sweep_busy, sweep_done});
        end
        tests++;
        if (sweep_tt !== 16'h0000 || sweep_err_cnt !== 5'd0) begin
            fails++;
            $display("FAIL reset_sweep_regs: got tt=%h cnt=%0d required 0000/0", sweep_tt, sweep_err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests++;
        if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got cfg_ready=%b in_ready=%b required 1/1", cfg_ready, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vecs [4];
        logic       exps [4];
        vecs = '{4'd0, 4'd4, 4'd9, 4'd15};
        exps = '{1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_vec = vecs[i];
            step();
            tests++;
            if (out_valid !== 1'b1 || out_bit !== exps[i]) begin
                fails++;
                $display("FAIL b2b_vec%0d: got valid=%b bit=%b required 1/%b", vecs[i], out_valid, out_bit, exps[i]);
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'd4;
        step();
        in_vec = 4'd15;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bit !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got in_ready=%b valid=%b bit=%b required 0/1/1", i, in_ready, out_valid, out_bit);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got in_ready=%b required 1", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0) begin
            fails++;
            $display("FAIL bp_resume_vec15: got valid=%b bit=%b required 1/0", out_valid, out_bit);
        end
        in_vec = 4'd9;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
            fails++;
            $display("FAIL bp_resume_vec9: got valid=%b bit=%b required 1/1", out_valid, out_bit);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_sweep_default();
        int done_at;
        int busy_cycles;
        sweep_exp   = 16'h5215;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        in_valid    = 1'b1;
        in_vec      = 4'd0;
        #1;
        tests++;
        if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL sweep_blocks_io: got in_ready=%b cfg_ready=%b required 0/0", in_ready, cfg_ready);
        end
        in_valid    = 1'b0;
        done_at     = -1;
        busy_cycles = 1;
        for (int c = 2; c <= 24; c++) begin
            step();
            if (sweep_busy) busy_cycles++;
            if (sweep_done && done_at < 0) done_at = c;
            if (!sweep_busy) break;
        end
        tests++;
        if (busy_cycles != 17 || done_at != 17) begin
            fails++;
            $display("FAIL sweep_timing: got busy=%0d done_at=%0d required 17/17", busy_cycles, done_at);
        end
        tests++;
        if (sweep_tt !== 16'h5215 || sweep_err_cnt !== 5'd0) begin
            fails++;
            $display("FAIL sweep_default_result: got tt=%h cnt=%0d required 5215/0", sweep_tt, sweep_err_cnt);
        end
        step();
        tests++;
        if (sweep_tt !== 16'h5215 || sweep_err_cnt !== 5'd0 || sweep_done !== 1'b0) begin
            fails++;
            $display("FAIL sweep_hold: got tt=%h cnt=%0d done=%b required 5215/0/0", sweep_tt, sweep_err_cnt, sweep_done);
        end
    endtask

    task automatic test_sweep_errors();
        int done_at;
        int busy_cycles;
        cfg_valid = 1'b1;
        cfg_tt    = 16'h0000;
        step();
        cfg_valid = 1'b0;
        run_sweep(16'hFFFF, done_at, busy_cycles);
        tests++;
        if (sweep_err_cnt !== 5'd16 || sweep_tt !== 16'h0000 || done_at != 17) begin
            fails++;
            $display("FAIL sweep_all_err: got cnt=%0d tt=%h done_at=%0d required 16/0000/17", sweep_err_cnt, sweep_tt, done_at);
        end
    endtask

    task automatic test_sweep_cfg_priority();
        int done_at;
        int busy_cycles;
        cfg_valid = 1'b1;
        cfg_tt    = 16'hA5C3;
        run_sweep(16'hA5C3, done_at, busy_cycles);
        cfg_valid = 1'b0;
        tests++;
        if (sweep_tt !== 16'hA5C3 || sweep_err_cnt !== 5'd0 || busy_cycles != 17) begin
            fails++;
            $display("FAIL sweep_cfg_same_cycle: got tt=%h cnt=%0d busy=%0d required a5c3/0/17", sweep_tt, sweep_err_cnt, busy_cycles);
        end
    endtask

    task automatic test_cfg_eval_same_cycle();
        cfg_valid = 1'b1;
        cfg_tt    = 16'h5215;
        step();
        cfg_tt    = 16'hFFFF;
        in_valid  = 1'b1;
        in_vec    = 4'd15;
        out_ready = 1'b1;
        step();
        cfg_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0) begin
            fails++;
            $display("FAIL cfg_eval_old_table: got valid=%b bit=%b required 1/0", out_valid, out_bit);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
            fails++;
            $display("FAIL cfg_eval_new_table: got valid=%b bit=%b required 1/1", out_valid, out_bit);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_sweep();
        int done_at;
        int busy_cycles;
        sweep_exp   = 16'h0000;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({sweep_busy, sweep_done, out_valid, out_bit} !== 4'b0000 || sweep_tt !== 16'h0000 || sweep_err_cnt !== 5'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b done=%b valid=%b bit=%b tt=%h cnt=%0d required all 0",
                     sweep_busy, sweep_done, out_valid, out_bit, sweep_tt, sweep_err_cnt);
        end
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        in_vec   = 4'd15;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0) begin
            fails++;
            $display("FAIL midreset_default_table: got valid=%b bit=%b required 1/0", out_valid, out_bit);
        end
        step();
        run_sweep(16'h5215, done_at, busy_cycles);
        tests++;
        if (sweep_tt !== 16'h5215 || sweep_err_cnt !== 5'd0 || done_at != 17 || busy_cycles != 17) begin
            fails++;
            $display("FAIL midreset_resweep: got tt=%h cnt=%0d done_at=%0d busy=%0d required 5215/0/17/17",
                     sweep_tt, sweep_err_cnt, done_at, busy_cycles);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_tt      = '0;
        in_valid    = 1'b0;
        in_vec      = '0;
        out_ready   = 1'b1;
        sweep_start = 1'b0;
        sweep_exp   = '0;

        test_reset();
        test_back_to_back();
        test_backpressure();
        test_sweep_default();
        test_sweep_errors();
        test_sweep_cfg_priority();
        test_cfg_eval_same_cycle();
        test_reset_mid_sweep();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
